// File: rtl/ctrl_fsm_pkg.sv
// Shared types, opcode map and ALU decode for the multi-cycle controller.
// HALT state and opcode only exist when CTRL_HALT_EN is defined.
package ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_A   = 4'd2,
        S_WRITE_R  = 4'd3,
        S_JUMP     = 4'd4,
        S_IND_RD   = 4'd5,
        S_IND_A    = 4'd6,
        S_IND_ADDR = 4'd7,
        S_IND_WR   = 4'd8,
        S_IND_DONE = 4'd9
`ifdef CTRL_HALT_EN
        , S_HALT   = 4'd10
`endif
    } state_e;

    localparam logic [4:0] OP_MOVLA  = 5'b00000;
    localparam logic [4:0] OP_MOVRA  = 5'b00001;
    localparam logic [4:0] OP_MOVAR  = 5'b00010;
    localparam logic [4:0] OP_MOVIRA = 5'b00011;
    localparam logic [4:0] OP_MOVIAR = 5'b00100;
    localparam logic [4:0] OP_ADDLA  = 5'b00111;
    localparam logic [4:0] OP_SUBLA  = 5'b01000;
    localparam logic [4:0] OP_ADDAR  = 5'b01001;
    localparam logic [4:0] OP_SUBAR  = 5'b01010;
    localparam logic [4:0] OP_ANDLA  = 5'b01011;
    localparam logic [4:0] OP_ANDAR  = 5'b01100;
    localparam logic [4:0] OP_ORLA   = 5'b01101;
    localparam logic [4:0] OP_ORAR   = 5'b01110;
    localparam logic [4:0] OP_XORLA  = 5'b01111;
    localparam logic [4:0] OP_XORAR  = 5'b10000;
    localparam logic [4:0] OP_INCR   = 5'b10001;
    localparam logic [4:0] OP_DECR   = 5'b10010;
    localparam logic [4:0] OP_NOTR   = 5'b10011;
    localparam logic [4:0] OP_ROLC   = 5'b10100;
    localparam logic [4:0] OP_RORC   = 5'b10101;
    localparam logic [4:0] OP_JZ     = 5'b10110;
    localparam logic [4:0] OP_JNZ    = 5'b10111;
    localparam logic [4:0] OP_JC     = 5'b11000;
    localparam logic [4:0] OP_JNC    = 5'b11001;
    localparam logic [4:0] OP_HALT   = 5'b11010;
    localparam logic [4:0] OP_JMP    = 5'b11011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_INC  = 4'd5;
    localparam logic [3:0] ALU_DEC  = 4'd6;
    localparam logic [3:0] ALU_NOT  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_ROR  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    // Returns {ALU_OP, ALU_MUX}; MUX=1 selects the register operand.
    function automatic logic [4:0] alu_decode(input logic [4:0] opc);
        logic [3:0] op;
        logic       mux;
        op  = ALU_ADD;
        mux = 1'b0;
        case (opc)
            OP_MOVLA, OP_MOVAR, OP_MOVIAR: op = ALU_PASS;
            OP_MOVRA, OP_MOVIRA: begin op = ALU_PASS; mux = 1'b1; end
            OP_ADDLA: op = ALU_ADD;
            OP_ADDAR: begin op = ALU_ADD; mux = 1'b1; end
            OP_SUBLA: op = ALU_SUB;
            OP_SUBAR: begin op = ALU_SUB; mux = 1'b1; end
            OP_ANDLA: op = ALU_AND;
            OP_ANDAR: begin op = ALU_AND; mux = 1'b1; end
            OP_ORLA:  op = ALU_OR;
            OP_ORAR:  begin op = ALU_OR; mux = 1'b1; end
            OP_XORLA: op = ALU_XOR;
            OP_XORAR: begin op = ALU_XOR; mux = 1'b1; end
            OP_INCR:  begin op = ALU_INC; mux = 1'b1; end
            OP_DECR:  begin op = ALU_DEC; mux = 1'b1; end
            OP_NOTR:  begin op = ALU_NOT; mux = 1'b1; end
            OP_ROLC:  begin op = ALU_ROL; mux = 1'b1; end
            OP_RORC:  begin op = ALU_ROR; mux = 1'b1; end
            default: ;
        endcase
        return {op, mux};
    endfunction

endpackage

// File: rtl/ctrl_mem_wait.sv
// Memory wait counter: retires on mem_ready, times out after WAIT_MAX
// stalled step cycles.
module ctrl_mem_wait #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic Reset_in,
    input  logic active,
    input  logic mem_ready,
    input  logic step_en,
    output logic retire,
    output logic timeout
);

    logic [7:0] cnt;
    logic       at_max;

    assign at_max  = (cnt == 8'(WAIT_MAX - 1));
    assign retire  = active & step_en & mem_ready;
    assign timeout = active & step_en & ~mem_ready & at_max;

    always_ff @(posedge clk) begin
        if (!Reset_in) begin
            cnt <= '0;
        end else if (retire | timeout | ~active) begin
            cnt <= '0;
        end else if (step_en) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle sequencing controller with memory handshake and step enable.
// Define CTRL_HALT_EN to add the HALT opcode/state.
module ctrl_fsm_mc
    import ctrl_fsm_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                Reset_in,
    input  logic                step_en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                Distination,
    input  logic                carryFlag,
    input  logic                zeroFlag,
    input  logic                mem_ready,
    output logic [3:0]          Stat_tst_out,
    output logic                Reset_out,
    output logic                ALU_MUX,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                PC_INC,
    output logic                PC_LOAD,
    output logic                RAM_RD,
    output logic                RAM_WR,
    output logic                RAM_MUX,
    output logic                IR_WR_SIGNAL,
    output logic                MDR_WR_SIGNAL,
    output logic                A_WR_SIGNAL,
    output logic                FLAG_WR_SIGNAL,
    output logic                ALU_EN,
    output logic                bus_err
);

    state_e     state, state_n, dec_next;
    logic [4:0] opc;
    logic [4:0] alu_dec;
    logic       legal, adv, mem_active, retire, timeout, rst_hold;

    assign opc     = opcode[4:0];
    assign legal   = ((opcode >> 5) == '0);
    assign alu_dec = legal ? alu_decode(opc) : 5'd0;
    assign ALU_OP  = ALU_OP_W'(alu_dec[4:1]);
    assign ALU_MUX = alu_dec[0];

    // Reset outranks step_en so nothing strobes while held in reset.
    assign adv        = step_en & Reset_in;
    assign mem_active = state inside {S_DECODE, S_IND_RD, S_WRITE_R, S_IND_WR};
    assign Stat_tst_out = state;

    ctrl_mem_wait #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clk       (clk),
        .Reset_in  (Reset_in),
        .active    (mem_active),
        .mem_ready (mem_ready),
        .step_en   (adv),
        .retire    (retire),
        .timeout   (timeout)
    );

    always_comb begin
        dec_next = S_FETCH;
        if (legal) begin
            case (opc)
                OP_MOVLA, OP_MOVRA, OP_ADDLA, OP_SUBLA,
                OP_ANDLA, OP_ORLA, OP_XORLA:
                    dec_next = S_EXEC_A;
                OP_ADDAR, OP_SUBAR, OP_ANDAR, OP_ORAR, OP_XORAR:
                    dec_next = Distination ? S_WRITE_R : S_EXEC_A;
                OP_MOVAR, OP_INCR, OP_DECR, OP_NOTR, OP_ROLC, OP_RORC:
                    dec_next = S_WRITE_R;
                OP_JMP: dec_next = S_JUMP;
                OP_JZ:  dec_next = zeroFlag   ? S_JUMP : S_FETCH;
                OP_JNZ: dec_next = !zeroFlag  ? S_JUMP : S_FETCH;
                OP_JC:  dec_next = carryFlag  ? S_JUMP : S_FETCH;
                OP_JNC: dec_next = !carryFlag ? S_JUMP : S_FETCH;
                OP_MOVIRA: dec_next = S_IND_RD;
                OP_MOVIAR: dec_next = S_IND_ADDR;
`ifdef CTRL_HALT_EN
                OP_HALT: dec_next = S_HALT;
`endif
                default: dec_next = S_FETCH;
            endcase
        end
    end

    always_comb begin
        state_n        = state;
        IR_WR_SIGNAL   = 1'b0;
        MDR_WR_SIGNAL  = 1'b0;
        A_WR_SIGNAL    = 1'b0;
        FLAG_WR_SIGNAL = 1'b0;
        PC_INC         = 1'b0;
        PC_LOAD        = 1'b1;
        RAM_RD         = 1'b1;
        RAM_WR         = 1'b1;
        RAM_MUX        = 1'b0;
        ALU_EN         = 1'b0;
        unique case (state)
            S_FETCH: if (adv) begin
                IR_WR_SIGNAL = 1'b1;
                state_n      = S_DECODE;
            end
            S_DECODE: begin
                RAM_RD = 1'b0;
                if (retire) begin
                    MDR_WR_SIGNAL = 1'b1;
                    PC_INC        = 1'b1;
                    state_n       = dec_next;
                end
            end
            S_EXEC_A: begin
                ALU_EN = 1'b1;
                if (adv) begin
                    A_WR_SIGNAL    = 1'b1;
                    FLAG_WR_SIGNAL = 1'b1;
                    state_n        = S_FETCH;
                end
            end
            S_WRITE_R: begin
                RAM_WR = 1'b0;
                ALU_EN = 1'b1;
                if (retire) begin
                    FLAG_WR_SIGNAL = 1'b1;
                    state_n        = S_FETCH;
                end
            end
            S_JUMP: begin
                PC_LOAD = 1'b0;
                if (adv) state_n = S_FETCH;
            end
            S_IND_RD: begin
                RAM_RD  = 1'b0;
                RAM_MUX = 1'b1;
                if (retire) begin
                    MDR_WR_SIGNAL = 1'b1;
                    PC_INC        = 1'b1;
                    state_n       = S_IND_A;
                end
            end
            S_IND_A: begin
                ALU_EN = 1'b1;
                if (adv) begin
                    A_WR_SIGNAL    = 1'b1;
                    FLAG_WR_SIGNAL = 1'b1;
                    state_n        = S_FETCH;
                end
            end
            S_IND_ADDR: if (adv) state_n = S_IND_WR;
            S_IND_WR: begin
                RAM_WR  = 1'b0;
                RAM_MUX = 1'b1;
                if (retire) state_n = S_IND_DONE;
            end
            S_IND_DONE: if (adv) state_n = S_FETCH;
`ifdef CTRL_HALT_EN
            S_HALT: state_n = S_HALT;
`endif
            default: state_n = S_FETCH;
        endcase
        if (timeout) state_n = S_FETCH;
    end

    always_ff @(posedge clk) begin
        if (!Reset_in) begin
            state     <= S_FETCH;
            bus_err   <= 1'b0;
            rst_hold  <= 1'b1;
            Reset_out <= 1'b1;
        end else begin
            state     <= state_n;
            rst_hold  <= 1'b0;
            Reset_out <= rst_hold;
            if (timeout) bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Directed bench for ctrl_fsm_mc (default build, CTRL_HALT_EN undefined).
module tb_ctrl_fsm_mc;

    logic       clk = 1'b0;
    logic       Reset_in, step_en, Distination, carryFlag, zeroFlag, mem_ready;
    logic [4:0] opcode;
    logic [3:0] Stat_tst_out, ALU_OP;
    logic       Reset_out, ALU_MUX, PC_INC, PC_LOAD, RAM_RD, RAM_WR, RAM_MUX;
    logic       IR_WR_SIGNAL, MDR_WR_SIGNAL, A_WR_SIGNAL, FLAG_WR_SIGNAL;
    logic       ALU_EN, bus_err;
    logic [13:0] obs;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ctrl_fsm_mc dut (
        .clk(clk), .Reset_in(Reset_in), .step_en(step_en), .opcode(opcode),
        .Distination(Distination), .carryFlag(carryFlag), .zeroFlag(zeroFlag),
        .mem_ready(mem_ready), .Stat_tst_out(Stat_tst_out), .Reset_out(Reset_out),
        .ALU_MUX(ALU_MUX), .ALU_OP(ALU_OP), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD),
        .RAM_RD(RAM_RD), .RAM_WR(RAM_WR), .RAM_MUX(RAM_MUX),
        .IR_WR_SIGNAL(IR_WR_SIGNAL), .MDR_WR_SIGNAL(MDR_WR_SIGNAL),
        .A_WR_SIGNAL(A_WR_SIGNAL), .FLAG_WR_SIGNAL(FLAG_WR_SIGNAL),
        .ALU_EN(ALU_EN), .bus_err(bus_err)
    );

    // {state, IR MDR PCINC AWR FWR, RD WR PCLOAD ALUEN MUX}
    assign obs = {Stat_tst_out, IR_WR_SIGNAL, MDR_WR_SIGNAL, PC_INC,
                  A_WR_SIGNAL, FLAG_WR_SIGNAL, RAM_RD, RAM_WR, PC_LOAD,
                  ALU_EN, RAM_MUX};

    localparam logic [13:0] F_GO    = 14'b0000_10000_11100;
    localparam logic [13:0] F_IDLE  = 14'b0000_00000_11100;
    localparam logic [13:0] D_GO    = 14'b0001_01100_01100;
    localparam logic [13:0] EA_GO   = 14'b0010_00011_11110;
    localparam logic [13:0] WR_WAIT = 14'b0011_00000_10110;
    localparam logic [13:0] WR_GO   = 14'b0011_00001_10110;
    localparam logic [13:0] JMP_ST  = 14'b0100_00000_11000;
    localparam logic [13:0] IR_WAIT = 14'b0101_00000_01101;
    localparam logic [13:0] IR_GO   = 14'b0101_01100_01101;
    localparam logic [13:0] IA_IDLE = 14'b0110_00000_11110;
    localparam logic [13:0] IA_GO   = 14'b0110_00011_11110;
    localparam logic [13:0] IADDR   = 14'b0111_00000_11100;
    localparam logic [13:0] IW_WAIT = 14'b1000_00000_10101;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_por();
        logic ro [4];
        ro = '{1'b1, 1'b1, 1'b1, 1'b0};
        tick();
        for (int i = 0; i < 4; i++) begin
            Reset_in = (i >= 1);
            #1;
            checks++;
            if (obs !== F_IDLE) begin
                errors++;
                $display("FAIL por_outputs cyc%0d got=%b want=%b", i, obs, F_IDLE);
            end
            checks++;
            if (Reset_out !== ro[i] || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL por_reset_out cyc%0d got ro=%b be=%b want ro=%b be=0",
                         i, Reset_out, bus_err, ro[i]);
            end
            tick();
        end
    endtask

    task automatic test_alu_decode();
        logic [4:0] ops [6];
        logic [4:0] want [6];
        ops  = '{5'b01000, 5'b10000, 5'b10101, 5'b00000, 5'b10110, 5'b00011};
        want = '{5'b0001_0, 5'b0100_1, 5'b1001_1, 5'b1010_0, 5'b0000_0, 5'b1010_1};
        step_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            #1;
            checks++;
            if ({ALU_OP, ALU_MUX} !== want[i]) begin
                errors++;
                $display("FAIL alu_decode op=%b got=%b want=%b",
                         ops[i], {ALU_OP, ALU_MUX}, want[i]);
            end
        end
        tick();
    endtask

    task automatic test_addla();
        logic [13:0] e [4];
        int na = 0;
        int nf = 0;
        e = '{F_GO, D_GO, EA_GO, F_IDLE};
        opcode = 5'b00111;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_en = (i < 3);
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL addla_seq cyc%0d got=%b want=%b", i, obs, e[i]);
            end
            if (i == 1) begin
                checks++;
                if (ALU_OP !== 4'b0000 || ALU_MUX !== 1'b0) begin
                    errors++;
                    $display("FAIL addla_alu got=%b/%b want=0000/0", ALU_OP, ALU_MUX);
                end
            end
            na += int'(A_WR_SIGNAL);
            nf += int'(FLAG_WR_SIGNAL);
            tick();
        end
        checks++;
        if (na != 1 || nf != 1) begin
            errors++;
            $display("FAIL addla_pulses got a=%0d f=%0d want 1/1", na, nf);
        end
    endtask

    task automatic test_addar_wait();
        logic [13:0] e [7];
        int nwr = 0;
        int nf = 0;
        e = '{F_GO, D_GO, WR_WAIT, WR_WAIT, WR_WAIT, WR_GO, F_IDLE};
        opcode = 5'b01001;
        Distination = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step_en = (i < 6);
            mem_ready = !(i >= 2 && i <= 4);
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL addar_seq cyc%0d got=%b want=%b", i, obs, e[i]);
            end
            if (i == 1) begin
                checks++;
                if (ALU_MUX !== 1'b1) begin
                    errors++;
                    $display("FAIL addar_mux got=%b want=1", ALU_MUX);
                end
            end
            nwr += int'(!RAM_WR);
            nf  += int'(FLAG_WR_SIGNAL);
            tick();
        end
        checks++;
        if (nwr != 4 || nf != 1) begin
            errors++;
            $display("FAIL addar_counts got wr=%0d f=%0d want 4/1", nwr, nf);
        end
        Distination = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_jz();
        logic [13:0] e0 [3];
        logic [13:0] e1 [4];
        e0 = '{F_GO, D_GO, F_IDLE};
        e1 = '{F_GO, D_GO, JMP_ST, F_IDLE};
        opcode = 5'b10110;
        mem_ready = 1'b1;
        zeroFlag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_en = (i < 2);
            #1;
            checks++;
            if (obs !== e0[i]) begin
                errors++;
                $display("FAIL jz_not_taken cyc%0d got=%b want=%b", i, obs, e0[i]);
            end
            tick();
        end
        zeroFlag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_en = (i < 3);
            #1;
            checks++;
            if (obs !== e1[i]) begin
                errors++;
                $display("FAIL jz_taken cyc%0d got=%b want=%b", i, obs, e1[i]);
            end
            tick();
        end
        zeroFlag = 1'b0;
    endtask

    task automatic test_illegal();
        logic [4:0] ops [2];
        ops = '{5'b00101, 5'b11010};
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
`ifndef CTRL_HALT_EN
            opcode = ops[k];
            for (int i = 0; i < 3; i++) begin
                step_en = (i < 2);
                #1;
                checks++;
                if (obs !== ((i == 0) ? F_GO : (i == 1) ? D_GO : F_IDLE)) begin
                    errors++;
                    $display("FAIL illegal op=%b cyc%0d got=%b", ops[k], i, obs);
                end
                tick();
            end
`endif
        end
    endtask

    task automatic test_timeout();
        logic [13:0] ex;
        opcode = 5'b00100;
        for (int i = 0; i < 19; i++) begin
            step_en = (i < 18);
            mem_ready = (i < 2);
            ex = (i == 0) ? F_GO : (i == 1) ? D_GO : (i == 2) ? IADDR :
                 (i <= 17) ? IW_WAIT : F_IDLE;
            #1;
            checks++;
            if (obs !== ex || bus_err !== (i == 18)) begin
                errors++;
                $display("FAIL timeout cyc%0d got=%b be=%b want=%b be=%b",
                         i, obs, bus_err, ex, (i == 18));
            end
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus_err !== 1'b1) begin
            errors++;
            $display("FAIL bus_err_sticky got=%b want=1", bus_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [13:0] e [10];
        logic ro [10];
        logic be [10];
        e  = '{F_GO, D_GO, IADDR, IW_WAIT, IW_WAIT, IW_WAIT,
               F_IDLE, F_IDLE, F_IDLE, F_IDLE};
        ro = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        be = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        opcode = 5'b00100;
        for (int i = 0; i < 10; i++) begin
            Reset_in = !(i == 5 || i == 6);
            step_en = (i < 7);
            mem_ready = (i < 2);
            #1;
            checks++;
            if (obs !== e[i] || Reset_out !== ro[i] || bus_err !== be[i]) begin
                errors++;
                $display("FAIL reset_mid cyc%0d got=%b ro=%b be=%b want=%b ro=%b be=%b",
                         i, obs, Reset_out, bus_err, e[i], ro[i], be[i]);
            end
            tick();
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_step_en();
        logic [13:0] e [8];
        logic st [8];
        e  = '{F_IDLE, F_GO, D_GO, IR_WAIT, IR_GO, IA_IDLE, IA_GO, F_IDLE};
        st = '{0, 1, 1, 0, 1, 0, 1, 0};
        opcode = 5'b00011;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_en = st[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL step_en cyc%0d got=%b want=%b", i, obs, e[i]);
            end
            tick();
        end
    endtask

    initial begin
        Reset_in = 1'b0;
        step_en = 1'b0;
        opcode = 5'b00000;
        Distination = 1'b0;
        carryFlag = 1'b0;
        zeroFlag = 1'b0;
        mem_ready = 1'b0;
        test_reset_por();
        test_alu_decode();
        test_addla();
        test_addar_wait();
        test_jz();
        test_illegal();
        test_timeout();
        test_reset_mid_wait();
        test_step_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm_mc.md
Name: ctrl_fsm_mc

Overview:
- Parametrised multi-cycle instruction-sequencing controller; successor to the fixed 5-bit-opcode accumulator controller.
- Decodes the opcode into ALU_OP/ALU_MUX and steps a Moore FSM through fetch/decode/execute/write-back.
- Adds a variable-latency memory handshake (mem_ready) with a timeout, and a clock-enable input in place of an internal clock divider.
- Sits between the IR/flag registers and the datapath (PC, MDR, A, ALU, RAM).

Parameters:
- OPCODE_W, 5, opcode width; encodings occupy the low 5 bits, upper bits must be 0 or the opcode decodes as illegal.
- ALU_OP_W, 4, ALU_OP width; codes zero-extended.
- WAIT_MAX, 15, max cycles a memory state waits for mem_ready before timeout (1..255).

Ports:
- clk in 1: system clock.
- Reset_in in 1: one clock; reset is synchronous and active-low.
- step_en in 1: FSM advances only when high; outputs hold otherwise.
- opcode in OPCODE_W: IR opcode field.
- Distination in 1: 0 = result to A, 1 = result to RAM.
- carryFlag, zeroFlag in 1: flag register.
- mem_ready in 1: RAM access complete this cycle.
- Stat_tst_out out 4: current state code.
- Reset_out out 1: high during reset and one cycle after.
- ALU_MUX out 1; ALU_OP out ALU_OP_W: combinational decode of opcode.
- PC_INC out 1; PC_LOAD out 1 (active-low).
- RAM_RD, RAM_WR out 1 (active-low).
- RAM_MUX out 1: 0 = PC address, 1 = indirect address.
- IR_WR_SIGNAL, MDR_WR_SIGNAL, A_WR_SIGNAL, FLAG_WR_SIGNAL out 1: one-cycle write strobes.
- ALU_EN out 1.
- bus_err out 1: sticky timeout flag.

Behaviour:
- Reset (Reset_in=0 at clk rising edge): state=FETCH, wait counter=0, bus_err=0, Reset_out=1.
- Out of reset: all strobes 0, PC_INC=0, ALU_EN=0, RAM_RD=RAM_WR=PC_LOAD=1.
- Reset takes priority over step_en and over a memory wait in progress.
- States (Stat_tst_out code): FETCH 0, DECODE 1, EXEC_A 2, WRITE_R 3, JUMP 4, IND_RD 5, IND_A 6, IND_ADDR 7, IND_WR 8, IND_DONE 9, HALT 10 (only with option).
- Memory states: DECODE, IND_RD (RAM_RD=0), WRITE_R, IND_WR (RAM_WR=0).
  - Each holds while step_en=1 and mem_ready=0, incrementing the wait counter.
  - It retires on mem_ready=1 (counter cleared).
  - If the counter reaches WAIT_MAX without mem_ready: set bus_err, go to FETCH, suppress all strobes.
- Non-memory states retire on the first step_en=1 cycle.
- Strobes (IR_WR in FETCH, MDR_WR+PC_INC in DECODE/IND_RD, A_WR in EXEC_A/IND_A, FLAG_WR in EXEC_A/WRITE_R/IND_A) assert only in the retiring cycle. This gives exactly one pulse per state visit.
- Level outputs (RAM_RD/WR, RAM_MUX, ALU_EN, PC_LOAD=0 in JUMP) are decoded from state alone.
- DECODE transitions:
  - MOV/ALU-literal → EXEC_A.
  - ALU-A,R → EXEC_A if Distination=0, else WRITE_R.
  - MOVAR/INCR/DECR/NOTR/ROLC/RORC → WRITE_R.
  - JMP → JUMP.
  - JZ/JNZ/JC/JNC → JUMP if condition true, else FETCH.
  - MOVIRA → IND_RD.
  - MOVIAR → IND_ADDR.
  - Illegal opcode → FETCH.
- Indirect sequences: IND_RD → IND_A → FETCH; IND_ADDR → IND_WR → IND_DONE → FETCH.
- All other execute states → FETCH.
- Flags are sampled in the DECODE retiring cycle.
- bus_err clears only on reset.
- Reset_out is registered: 1 in the reset cycle and the next cycle, then 0.

Optional Feature:
- Macro CTRL_HALT_EN.
- Defined:
  - Opcode 11010 (HALT) goes DECODE → HALT.
  - HALT drives all outputs inactive and holds until reset.
  - Stat_tst_out=10.
- Undefined: 11010 is illegal (→ FETCH); HALT state does not exist.

Decomposition:
- Package ctrl_fsm_pkg holds:
  - state enum (4-bit, explicit codes above);
  - 5-bit opcode localparams;
  - ALU_OP code localparams;
  - a function mapping opcode→{ALU_OP, ALU_MUX}.
- One sub-module, ctrl_mem_wait: the wait counter and timeout compare, with inputs active/mem_ready/step_en and outputs retire/timeout.

Test Plan:
- Reset: Reset_in=0 for 2 cycles mid-IND_WR → Stat_tst_out=0, RAM_WR=1, bus_err=0, Reset_out=1 for the two cycles plus one.
- ADDLA (00111), mem_ready=1 always → states 0,1,2,0; ALU_OP=0000, ALU_MUX=0; A_WR and FLAG_WR pulse once in state 2.
- ADDAR (01001), Distination=1, mem_ready delayed 3 cycles in WRITE_R → RAM_WR=0 for 4 cycles; FLAG_WR single pulse on the 4th.
- JZ (10110) with zeroFlag=0 → 0,1,0, PC_LOAD stays 1; with zeroFlag=1 → 0,1,4,0, PC_LOAD=0 in state 4.
- MOVIAR (00100), WAIT_MAX=15, mem_ready stuck 0 in IND_WR → returns to FETCH after 15 cycles; bus_err=1 and stays 1; no MDR/A strobes.
- step_en toggling 1,0,1 during MOVIRA (00011) → no state advance and no strobe while 0; sequence 0,1,5,6,0 otherwise unchanged.
